// File: rtl/spi_slave_byte.sv
// SPI mode-0 responder (CPOL=0, CPHA=0, MSB first).
// sck/cs/mosi are oversampled on clk through short synchroniser chains.
// Each received byte is delivered as a one-cycle rx_valid pulse.
// Transmit bytes come from a single-entry valid/ready buffer.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | cs high: miso parked at 1, waiting for a cs falling edge
// ACTIVE | cs low: sample mosi on sck rise, shift miso on sck fall
module spi_slave_byte #(
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2,
  parameter logic [DATA_W-1:0] IDLE_FILL = {DATA_W{1'b1}}
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sck,
  input  logic              cs,
  input  logic              mosi,
  output logic              miso,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              tx_under,
  output logic              busy
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t state, state_next;

  logic [SYNC_STAGES-1:0] sck_sync, cs_sync, mosi_sync;
  logic sck_prev, cs_prev;
  logic sck_s, cs_s, mosi_s;
  logic sck_rise, sck_fall, cs_rise, cs_fall;

  logic [DATA_W-1:0] tx_buf;
  logic              tx_buf_full;
  logic [DATA_W-1:0] tx_shift;
  logic [DATA_W-1:0] load_byte;
  logic [DATA_W-2:0] rx_shift;
  logic [DATA_W-1:0] rx_next;
  logic [CNT_W-1:0]  bit_cnt;

  logic load_tx, shift_tx, sample_rx, abort;

  assign sck_s  = sck_sync[SYNC_STAGES-1];
  assign cs_s   = cs_sync[SYNC_STAGES-1];
  assign mosi_s = mosi_sync[SYNC_STAGES-1];

  assign sck_rise = ~sck_prev & sck_s;
  assign sck_fall = sck_prev & ~sck_s;
  assign cs_rise  = ~cs_prev & cs_s;
  assign cs_fall  = cs_prev & ~cs_s;

  // An empty buffer at a byte start sends the idle fill pattern instead.
  assign load_byte = tx_buf_full ? tx_buf : IDLE_FILL;
  assign rx_next   = {rx_shift, mosi_s};

  // miso is the shifter MSB; the shifter is parked at all-ones when idle.
  assign miso     = tx_shift[DATA_W-1];
  assign tx_ready = ~tx_buf_full;
  assign busy     = (state == ACTIVE);

  // Synchronise the SPI pins and keep the previous sck/cs for edge detection.
  always_ff @(posedge clk) begin
    if (reset) begin
      sck_sync  <= '0;
      cs_sync   <= '1;
      mosi_sync <= '1;
      sck_prev  <= 1'b0;
      cs_prev   <= 1'b1;
    end else begin
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0], sck};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      sck_prev  <= sck_s;
      cs_prev   <= cs_s;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next state and per-cycle datapath strobes; a cs rise overrides any sck edge.
  always_comb begin
    state_next = state;
    load_tx    = 1'b0;
    shift_tx   = 1'b0;
    sample_rx  = 1'b0;
    abort      = 1'b0;
    case (state)
      IDLE: begin
        if (cs_fall) begin
          state_next = ACTIVE;
          load_tx    = 1'b1;
        end
      end
      ACTIVE: begin
        if (cs_rise) begin
          state_next = IDLE;
          abort      = 1'b1;
        end else if (sck_rise) begin
          sample_rx = 1'b1;
        end else if (sck_fall) begin
          if (bit_cnt == '0) load_tx  = 1'b1;
          else               shift_tx = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Transmit buffer: accept only while empty, so accept and consume never overlap.
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_buf      <= '0;
      tx_buf_full <= 1'b0;
    end else if (tx_valid && !tx_buf_full) begin
      tx_buf      <= tx_data;
      tx_buf_full <= 1'b1;
    end else if (load_tx && tx_buf_full) begin
      tx_buf_full <= 1'b0;
    end
  end

  // Transmit shifter and underrun pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_shift <= '1;
      tx_under <= 1'b0;
    end else begin
      tx_under <= 1'b0;
      if (abort) begin
        tx_shift <= '1;
      end else if (load_tx) begin
        tx_shift <= load_byte;
        tx_under <= ~tx_buf_full;
      end else if (shift_tx) begin
        tx_shift <= {tx_shift[DATA_W-2:0], 1'b1};
      end
    end
  end

  // Receive shifter, bit counter and received-byte pulse; partial bytes are dropped on abort.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_shift <= '0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      bit_cnt  <= '0;
    end else begin
      rx_valid <= 1'b0;
      if (abort) begin
        rx_shift <= '0;
        bit_cnt  <= '0;
      end else if (sample_rx) begin
        rx_shift <= rx_next[DATA_W-2:0];
        if (bit_cnt == LAST_BIT) begin
          rx_data  <= rx_next;
          rx_valid <= 1'b1;
          bit_cnt  <= '0;
        end else begin
          bit_cnt <= bit_cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_slave_byte.sv
// Bench for spi_slave_byte: a behavioural SPI master plus byte scoreboards.
module tb_spi_slave_byte;

  localparam int HALF = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       sck = 1'b0;
  logic       cs = 1'b1;
  logic       mosi = 1'b1;
  logic       miso;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       tx_under;
  logic       busy;

  int n_cmp = 0;
  int n_fail = 0;
  int under_cnt = 0;
  logic [7:0] rx_got[$];
  logic [7:0] rx_exp[$];
  logic [7:0] mi_exp[$];

  spi_slave_byte dut (
    .clk(clk), .reset(reset), .sck(sck), .cs(cs), .mosi(mosi), .miso(miso),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .tx_under(tx_under), .busy(busy)
  );

  always #5 clk = ~clk;

  // Capture received bytes and underrun pulses away from the active edge.
  always @(negedge clk) begin
    if (!reset) begin
      if (rx_valid) rx_got.push_back(rx_data);
      if (tx_under) under_cnt = under_cnt + 1;
    end
  end

  initial begin
    #500us;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Master: shift nbits of mo MSB first; optionally raise cs together with the last sck fall.
  task automatic spi_xfer(input logic [7:0] mo, input int nbits, input bit end_cs,
                          output logic [7:0] mi);
    mi = 8'h00;
    for (int i = 7; i >= 8 - nbits; i--) begin
      mosi = mo[i];
      tick(HALF);
      mi[i] = miso;
      sck = 1'b1;
      tick(HALF);
      sck = 1'b0;
      if (end_cs && i == 8 - nbits) cs = 1'b1;
    end
    mosi = 1'b1;
  endtask

  task automatic push_tx(input logic [7:0] d);
    int w;
    w = 0;
    @(negedge clk);
    while (!tx_ready && w < 400) begin
      @(negedge clk);
      w++;
    end
    n_cmp++;
    if (!tx_ready) begin
      n_fail++;
      $display("FAIL tx_ready_wait: got tx_ready=%b expected 1 within 400 cycles", tx_ready);
    end
    tx_data  = d;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic test_reset;
    tick(3);
    reset = 1'b0;
    tick(1);
    n_cmp += 6;
    if (miso !== 1'b1)     begin n_fail++; $display("FAIL reset_miso: got %b expected 1", miso); end
    if (tx_ready !== 1'b1) begin n_fail++; $display("FAIL reset_tx_ready: got %b expected 1", tx_ready); end
    if (busy !== 1'b0)     begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rx_valid: got %b expected 0", rx_valid); end
    if (tx_under !== 1'b0) begin n_fail++; $display("FAIL reset_tx_under: got %b expected 0", tx_under); end
    if (rx_data !== 8'h00) begin n_fail++; $display("FAIL reset_rx_data: got %h expected 00", rx_data); end
    tick(30);
    n_cmp += 3;
    if (rx_got.size() != 0) begin n_fail++; $display("FAIL idle_rx_valid: got %0d pulses expected 0", rx_got.size()); end
    if (miso !== 1'b1)      begin n_fail++; $display("FAIL idle_miso: got %b expected 1", miso); end
    if (under_cnt != 0)     begin n_fail++; $display("FAIL idle_under: got %0d expected 0", under_cnt); end
  endtask

  task automatic test_single;
    logic [7:0] mi, eb, gb;
    int u0;
    u0 = under_cnt;
    push_tx(8'hA5);
    // A second offer while full must be ignored.
    @(negedge clk);
    tx_data = 8'h77; tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    n_cmp++;
    if (tx_ready !== 1'b0) begin n_fail++; $display("FAIL single_ready_full: got %b expected 0", tx_ready); end
    rx_exp.push_back(8'h3C);
    mi_exp.push_back(8'hA5);
    tick(1);
    cs = 1'b0;
    spi_xfer(8'h3C, 8, 1'b1, mi);
    tick(8);
    eb = mi_exp.pop_front();
    n_cmp += 4;
    if (mi !== eb)             begin n_fail++; $display("FAIL single_miso: got %h expected %h", mi, eb); end
    if (tx_ready !== 1'b1)     begin n_fail++; $display("FAIL single_ready_after: got %b expected 1", tx_ready); end
    if (under_cnt - u0 != 0)   begin n_fail++; $display("FAIL single_under: got %0d expected 0", under_cnt - u0); end
    if (busy !== 1'b0)         begin n_fail++; $display("FAIL single_busy_end: got %b expected 0", busy); end
    while (rx_exp.size() > 0) begin
      eb = rx_exp.pop_front();
      n_cmp++;
      if (rx_got.size() == 0) begin n_fail++; $display("FAIL single_rx: got none expected %h", eb); end
      else begin
        gb = rx_got.pop_front();
        if (gb !== eb) begin n_fail++; $display("FAIL single_rx: got %h expected %h", gb, eb); end
      end
    end
    n_cmp++;
    if (rx_got.size() != 0) begin n_fail++; $display("FAIL single_rx_extra: got %0d extra expected 0", rx_got.size()); end
    rx_got.delete();
  endtask

  task automatic test_underrun;
    logic [7:0] mi, eb, gb;
    int u0;
    u0 = under_cnt;
    rx_exp.push_back(8'h81);
    mi_exp.push_back(8'hFF);
    cs = 1'b0;
    tick(1);
    n_cmp++;
    spi_xfer(8'h81, 8, 1'b1, mi);
    tick(8);
    eb = mi_exp.pop_front();
    n_cmp++;
    if (mi !== eb) begin n_fail++; $display("FAIL under_miso: got %h expected %h", mi, eb); end
    if (under_cnt - u0 != 1) begin n_fail++; $display("FAIL under_pulses: got %0d expected 1", under_cnt - u0); end
    while (rx_exp.size() > 0) begin
      eb = rx_exp.pop_front();
      n_cmp++;
      if (rx_got.size() == 0) begin n_fail++; $display("FAIL under_rx: got none expected %h", eb); end
      else begin
        gb = rx_got.pop_front();
        if (gb !== eb) begin n_fail++; $display("FAIL under_rx: got %h expected %h", gb, eb); end
      end
    end
    rx_got.delete();
  endtask

  task automatic test_back_to_back;
    logic [7:0] eb, gb;
    logic [7:0] mo[3];
    logic [7:0] refill[2];
    int u0;
    u0 = under_cnt;
    mo = '{8'h01, 8'h02, 8'h03};
    refill = '{8'h20, 8'h30};
    push_tx(8'h10);
    foreach (mo[k]) rx_exp.push_back(mo[k]);
    mi_exp.push_back(8'h10); mi_exp.push_back(8'h20); mi_exp.push_back(8'h30);
    tick(1);
    cs = 1'b0;
    fork
      begin
        logic [7:0] mi, e;
        for (int k = 0; k < 3; k++) begin
          spi_xfer(mo[k], 8, (k == 2), mi);
          e = mi_exp.pop_front();
          n_cmp++;
          if (mi !== e) begin n_fail++; $display("FAIL burst_miso[%0d]: got %h expected %h", k, mi, e); end
        end
      end
      begin
        for (int k = 0; k < 2; k++) push_tx(refill[k]);
      end
    join
    tick(8);
    n_cmp++;
    if (under_cnt - u0 != 0) begin n_fail++; $display("FAIL burst_under: got %0d expected 0", under_cnt - u0); end
    while (rx_exp.size() > 0) begin
      eb = rx_exp.pop_front();
      n_cmp++;
      if (rx_got.size() == 0) begin n_fail++; $display("FAIL burst_rx: got none expected %h", eb); end
      else begin
        gb = rx_got.pop_front();
        if (gb !== eb) begin n_fail++; $display("FAIL burst_rx: got %h expected %h", gb, eb); end
      end
    end
    n_cmp++;
    if (rx_got.size() != 0) begin n_fail++; $display("FAIL burst_rx_extra: got %0d extra expected 0", rx_got.size()); end
    rx_got.delete();
  endtask

  task automatic test_cs_abort;
    logic [7:0] mi, eb, gb;
    int u0;
    u0 = under_cnt;
    cs = 1'b0;
    spi_xfer(8'hAA, 5, 1'b0, mi);
    tick(HALF);
    cs = 1'b1;
    tick(8);
    n_cmp += 3;
    if (rx_got.size() != 0) begin n_fail++; $display("FAIL abort_rx_valid: got %0d pulses expected 0", rx_got.size()); end
    if (busy !== 1'b0)      begin n_fail++; $display("FAIL abort_busy: got %b expected 0", busy); end
    if (miso !== 1'b1)      begin n_fail++; $display("FAIL abort_miso: got %b expected 1", miso); end
    rx_exp.push_back(8'h55);
    mi_exp.push_back(8'hFF);
    cs = 1'b0;
    spi_xfer(8'h55, 8, 1'b1, mi);
    tick(8);
    eb = mi_exp.pop_front();
    n_cmp += 2;
    if (mi !== eb)           begin n_fail++; $display("FAIL abort_next_miso: got %h expected %h", mi, eb); end
    if (under_cnt - u0 != 2) begin n_fail++; $display("FAIL abort_under: got %0d expected 2", under_cnt - u0); end
    while (rx_exp.size() > 0) begin
      eb = rx_exp.pop_front();
      n_cmp++;
      if (rx_got.size() == 0) begin n_fail++; $display("FAIL abort_next_rx: got none expected %h", eb); end
      else begin
        gb = rx_got.pop_front();
        if (gb !== eb) begin n_fail++; $display("FAIL abort_next_rx: got %h expected %h", gb, eb); end
      end
    end
    rx_got.delete();
  endtask

  task automatic test_reset_mid;
    logic [7:0] mi, eb, gb;
    cs = 1'b0;
    tick(6);
    push_tx(8'h99);
    spi_xfer(8'hF0, 4, 1'b0, mi);
    n_cmp += 2;
    if (tx_ready !== 1'b0) begin n_fail++; $display("FAIL rstmid_ready_before: got %b expected 0", tx_ready); end
    if (busy !== 1'b1)     begin n_fail++; $display("FAIL rstmid_busy_before: got %b expected 1", busy); end
    reset = 1'b1;
    tick(1);
    n_cmp += 5;
    if (miso !== 1'b1)     begin n_fail++; $display("FAIL rstmid_miso: got %b expected 1", miso); end
    if (tx_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_ready: got %b expected 1", tx_ready); end
    if (busy !== 1'b0)     begin n_fail++; $display("FAIL rstmid_busy: got %b expected 0", busy); end
    if (rx_data !== 8'h00) begin n_fail++; $display("FAIL rstmid_rx_data: got %h expected 00", rx_data); end
    if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_rx_valid: got %b expected 0", rx_valid); end
    cs = 1'b1;
    tick(3);
    reset = 1'b0;
    tick(8);
    rx_got.delete();
    push_tx(8'h3C);
    rx_exp.push_back(8'hC3);
    mi_exp.push_back(8'h3C);
    tick(1);
    cs = 1'b0;
    spi_xfer(8'hC3, 8, 1'b1, mi);
    tick(8);
    eb = mi_exp.pop_front();
    n_cmp++;
    if (mi !== eb) begin n_fail++; $display("FAIL rstmid_next_miso: got %h expected %h", mi, eb); end
    while (rx_exp.size() > 0) begin
      eb = rx_exp.pop_front();
      n_cmp++;
      if (rx_got.size() == 0) begin n_fail++; $display("FAIL rstmid_next_rx: got none expected %h", eb); end
      else begin
        gb = rx_got.pop_front();
        if (gb !== eb) begin n_fail++; $display("FAIL rstmid_next_rx: got %h expected %h", gb, eb); end
      end
    end
    n_cmp++;
    if (rx_got.size() != 0) begin n_fail++; $display("FAIL rstmid_rx_extra: got %0d extra expected 0", rx_got.size()); end
    rx_got.delete();
  endtask

  initial begin
    test_reset();
    test_single();
    test_underrun();
    test_back_to_back();
    test_cs_abort();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
